uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//  Transmit byte buffer directly upstream of uart_tx. Bytes written from the AXI register side
//  queue in a synchronous FIFO. A small FSM pops them one at a time, drives uart_tx start_tx/data_in,
//  and waits for tx_done before launching the next byte. Turns the single tx_data register into a
//  back-to-back streaming path with full/empty/overflow status readable by software.
// PARAMETERS
//  DEPTH   16  FIFO entries; power of two, >=2
//  ADDR_W  4   log2(DEPTH); pointer width
// PORTS
//  clock       in   1         system clock (S_AXI_ACLK); single clock domain
//  resetn      in   1         synchronous, active-low reset
//  uart_en     in   1         uart_ctrl[0]; low = flush + hold idle
//  wr_en       in   1         one-cycle push strobe from register block (write to TX data reg)
//  wr_data     in   8         byte to push
//  clr_ovf     in   1         one-cycle strobe; clears overflow
//  tx_done     in   1         one-cycle pulse from uart_tx at end of stop bit
//  start_tx    out  1         one-cycle launch pulse to uart_tx
//  data_in     out  8         byte to uart_tx; stable from start_tx until tx_done
//  fifo_full   out  1         count == DEPTH
//  fifo_empty  out  1         count == 0
//  fifo_count  out  ADDR_W+1  entries held, 0..DEPTH
//  overflow    out  1         sticky: push attempted while full
//  busy        out  1         FSM not IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset (resetn low at a clock edge): wr_ptr=rd_ptr=count=0, state=IDLE, start_tx=0,
//   data_in=8'h00, overflow=0; fifo_empty=1, fifo_full=0, busy=0. Storage contents not reset.
//  All outputs registered or decoded from registers; no combinational path from inputs to outputs.
//  Push: wr_en & !fifo_full & uart_en -> mem[wr_ptr]=wr_data, wr_ptr+1 (wraps modulo DEPTH), count+1.
//  Push while full: byte dropped, FIFO unchanged, overflow<=1. Full is the registered status, so a
//   pop in the same cycle does not free space for that push.
//  Push with uart_en low: dropped; overflow unaffected.
//  FSM states IDLE, START, WAIT:
//   IDLE : uart_en & !fifo_empty -> START. On that edge: data_in<=mem[rd_ptr], start_tx<=1,
//          rd_ptr+1 (wraps), count-1.
//   START: start_tx<=0 on the next edge; -> WAIT unconditionally (exactly one cycle high).
//   WAIT : tx_done -> IDLE. data_in held throughout.
//   tx_done is ignored in IDLE and START.
//  Latency: byte pushed at edge E0 into an empty FIFO with FSM IDLE -> start_tx high from E1 to E2.
//   After tx_done at edge Ed, the next start_tx rises at Ed+1 if the FIFO is non-empty.
//  Push and pop on the same edge: count unchanged, both pointers advance.
//  clr_ovf: overflow<=0. If clr_ovf and an overflowing push occur in the same cycle, overflow<=1 (set wins).
//  uart_en low at any edge: state<=IDLE, start_tx<=0, pointers and count cleared (flush).
//   data_in and overflow are held. A transfer in flight is abandoned; no tx_done is awaited.
//  Wrap-around: pointers are ADDR_W bits wide. Full/empty are derived from count only, never from
//   pointer compare.
// TESTING
//  1 Reset: hold resetn=0 for 3 clocks with wr_en toggling -> all outputs at reset values,
//    fifo_empty=1, fifo_count=0.
//  2 Single byte: uart_en=1, push 8'hA5 at E0 -> start_tx=1 only E1..E2, data_in=8'hA5 until
//    tx_done; busy drops the cycle after tx_done.
//  3 Burst: push 8'h01..8'h10 (16) back-to-back while tx_done is delayed 20 cycles per byte ->
//    start_tx order 01..10, one per tx_done; fifo_count peaks at 15.
//  4 Overflow: hold tx_done low, push 17 bytes -> fifo_full=1 after the 17th push edge
//    (first byte already popped); 18th push sets overflow=1 and leaves count at 16;
//    clr_ovf -> overflow=0.
//  5 Wrap: push/drain 3 x DEPTH+5 bytes with random gaps -> output sequence equals input,
//    no loss, count never exceeds 16.
//  6 Flush: with 4 bytes queued and FSM in WAIT, drop uart_en for 1 cycle -> IDLE, count=0,
//    no further start_tx; a later tx_done is ignored.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the register block / uart_tx and the transmit FIFO.
// The master side drives the strobes; the slave side is the FIFO itself.
`timescale 1ns/1ps
interface uart_tx_fifo_if #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
);
    logic              uart_en;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              clr_ovf;
    logic              tx_done;
    logic              start_tx;
    logic [7:0]        data_in;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W:0]   fifo_count;
    logic              overflow;
    logic              busy;

    modport master (
        output uart_en, wr_en, wr_data, clr_ovf, tx_done,
        input  start_tx, data_in, fifo_full, fifo_empty, fifo_count, overflow, busy
    );

    modport slave (
        input  uart_en, wr_en, wr_data, clr_ovf, tx_done,
        output start_tx, data_in, fifo_full, fifo_empty, fifo_count, overflow, busy
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of uart_tx: queues register writes and launches one byte per
// tx_done, with count-based full/empty and a sticky overflow flag.
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic          clock,
    input  logic          resetn,
    uart_tx_fifo_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W+1)'(0);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_start_tx;
    logic [7:0]        r_data_in;
    logic              r_overflow;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_set;

    // Status decode and push/pop qualification; full is the registered count, so a same-cycle pop never frees room
    always_comb begin
        w_full    = (r_count == CNT_FULL);
        w_empty   = (r_count == CNT_ZERO);
        w_push    = bus.uart_en & bus.wr_en & ~w_full;
        w_ovf_set = bus.uart_en & bus.wr_en & w_full;
        w_pop     = bus.uart_en & (r_state == ST_IDLE) & ~w_empty;
    end

    // Launch sequencer next-state: disabling the UART always forces IDLE
    always_comb begin
        w_state_nxt = r_state;
        if (!bus.uart_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = w_pop ? ST_START : ST_IDLE;
                ST_START: w_state_nxt = ST_WAIT;
                ST_WAIT:  w_state_nxt = bus.tx_done ? ST_IDLE : ST_WAIT;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clock) begin
        if (resetn && w_push) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    // Pointers, occupancy, launch pulse, output byte and sticky overflow
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wr_ptr   <= PTR_ZERO;
            r_rd_ptr   <= PTR_ZERO;
            r_count    <= CNT_ZERO;
            r_start_tx <= 1'b0;
            r_data_in  <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            r_start_tx <= w_pop;
            if (w_pop) begin
                r_data_in <= r_mem[r_rd_ptr];
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_overflow <= 1'b0;
            end
            if (!bus.uart_en) begin
                r_wr_ptr <= PTR_ZERO;
                r_rd_ptr <= PTR_ZERO;
                r_count  <= CNT_ZERO;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_ONE;
                    2'b01:   r_count <= r_count - CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign bus.start_tx   = r_start_tx;
    assign bus.data_in    = r_data_in;
    assign bus.fifo_full  = w_full;
    assign bus.fifo_empty = w_empty;
    assign bus.fifo_count = r_count;
    assign bus.overflow   = r_overflow;
    assign bus.busy       = (r_state != ST_IDLE) | ~w_empty;
endmodule
